fpga_reset_conditioner: RTL



---
 rtl/fpga_reset_conditioner.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fpga_reset_conditioner.sv
// Reset conditioner: synchronises straps and the reset button, debounces the button (RESET_COND_DEBOUNCE_EN), stretches reset, latches straps on release.
// Latency: power-on HOLD_CYCLES edges; press SYNC_STAGES+DEBOUNCE_CYCLES+1 edges; release adds HOLD_CYCLES (debounce term absent when disabled).
// Backpressure: none; free-running level outputs, no handshake.
module fpga_reset_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int HOLD_CYCLES     = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rst_btn_i,
    input  logic boot_select_i,
    input  logic execute_from_flash_i,
    output logic sys_rst_no,
    output logic boot_select_o,
    output logic execute_from_flash_o,
    output logic rst_led_o
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [SYNC_STAGES-1:0] bs_sync_q;
    logic [SYNC_STAGES-1:0] eff_sync_q;
    logic                   btn_sync;
    logic                   bs_sync;
    logic                   eff_sync;
    logic                   btn_db;

    state_t                 state_q;
    state_t                 state_d;
    logic [HOLD_W-1:0]      hold_cnt_q;
    logic [HOLD_W-1:0]      hold_cnt_d;
    logic                   strap_load;
    logic                   rst_n_d;

    // Raw inputs are asynchronous to clk_i; new samples enter at bit 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_sync_q <= '0;
            bs_sync_q  <= '0;
            eff_sync_q <= '0;
        end else begin
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], rst_btn_i};
            bs_sync_q  <= {bs_sync_q[SYNC_STAGES-2:0], boot_select_i};
            eff_sync_q <= {eff_sync_q[SYNC_STAGES-2:0], execute_from_flash_i};
        end
    end

    assign btn_sync = btn_sync_q[SYNC_STAGES-1];
    assign bs_sync  = bs_sync_q[SYNC_STAGES-1];
    assign eff_sync = eff_sync_q[SYNC_STAGES-1];

`ifdef RESET_COND_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt;
    logic            btn_db_q;

    // The new level is accepted on the edge the counter would reach DEBOUNCE_CYCLES.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else if (btn_sync == btn_db_q) begin
            db_cnt   <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db_q <= btn_sync;
            db_cnt   <= '0;
        end else begin
            db_cnt   <= db_cnt + DB_W'(1);
        end
    end

    assign btn_db = btn_db_q;
`else
    logic [31:0] unused_db_cfg;

    assign unused_db_cfg = DEBOUNCE_CYCLES;
    assign btn_db        = btn_sync;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // A press always wins over an expiring stretch, so HOLD never leaks a RUN cycle.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        case (state_q)
            ST_ASSERT: begin
                if (!btn_db) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (btn_db) begin
                    state_d = ST_ASSERT;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (btn_db) begin
                    state_d = ST_ASSERT;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_comb begin
        strap_load = (state_q == ST_HOLD) && (state_d == ST_RUN);
        rst_n_d    = (state_d == ST_RUN);
    end

    // Straps and reset release share one edge so the system never sees stale straps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sys_rst_no           <= 1'b0;
            boot_select_o        <= 1'b0;
            execute_from_flash_o <= 1'b0;
        end else begin
            sys_rst_no <= rst_n_d;
            if (strap_load) begin
                boot_select_o        <= bs_sync;
                execute_from_flash_o <= eff_sync;
            end
        end
    end

    assign rst_led_o = sys_rst_no;

endmodule
